nic_fifo: RTL and testbench
===========================

NIC_FIFO -- requirements
Module: nic_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64: processor and network word width; bit 0 (MSB) of each network word is the virtual-channel (VC) bit.
REQ-002 SHALL have parameter DEPTH, default 4: entries per FIFO; power of two, >=2.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH)+1: occupancy counter width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 addr  input  2  register select: 00 IN_BUF, 01 IN_STATUS, 10 OUT_BUF, 11 OUT_STATUS.
REQ-007 d_in  input  DATA_W  processor write data.
REQ-008 nicEn  input  1  processor access enable.
REQ-009 nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn).
REQ-010 d_out  output  DATA_W  registered processor read data.
REQ-011 net_so  output  1  send strobe to router; net_do is valid.
REQ-012 net_ro  input  1  router ready to accept.
REQ-013 net_do  output  DATA_W  output FIFO head word.
REQ-014 net_polarity  input  1  current router phase.
REQ-015 net_si  input  1  router delivers net_di this cycle.
REQ-016 net_ri  output  1  NIC can accept a network word.
REQ-017 net_di  input  DATA_W  inbound network word.

Function
REQ-018 Output FIFO SHALL push d_in when nicEn && nicWrEn && addr==OUT_BUF && not full; when full, the word SHALL be dropped and sticky out_ovf set.
REQ-019 net_so SHALL be combinational: out not empty && net_ro && head[0]==~net_polarity; net_do SHALL always equal head (0 when empty).
REQ-020 Output FIFO SHALL pop on every cycle net_so=1; push and pop in the same cycle SHALL leave occupancy unchanged, including when full (pop frees the slot first).
REQ-021 net_ri SHALL be combinational: input FIFO not full; a net_si while full SHALL be ignored.
REQ-022 Input FIFO SHALL push net_di on net_si && net_ri.
REQ-023 Processor read (nicEn && !nicWrEn) at IN_BUF SHALL return head next cycle and pop it if not empty; if empty, SHALL return 0 without popping.
REQ-024 Simultaneous input push and pop SHALL leave occupancy unchanged; word order SHALL be strict FIFO in both directions.
REQ-025 IN_STATUS read SHALL return LSB = input not empty, bits [CNT_W:1] from LSB = input occupancy, all other bits 0.
REQ-026 OUT_STATUS read SHALL return LSB = output full, bits [CNT_W:1] = output occupancy, bit CNT_W+1 = out_ovf, others 0.
REQ-027 Processor write at OUT_STATUS SHALL clear out_ovf; writes to IN_BUF or IN_STATUS SHALL have no effect.
REQ-028 d_out SHALL update one cycle after a read; read of OUT_BUF SHALL return 0; d_out SHALL be 0 the cycle after any cycle with nicEn=0; d_out SHALL hold during writes.
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.

Reset
REQ-030 reset SHALL clear both FIFOs (pointers, occupancy), out_ovf, and d_out to 0; net_so=0, net_ri=1 in the cycle after reset.
REQ-031 reset SHALL override any concurrent push, pop or processor access; in-flight words SHALL be discarded.

Structure
REQ-032 Address codes and status bit positions SHALL live in shared package nic_pkg.
REQ-033 One sub-module nic_sync_fifo (DATA_W, DEPTH; push, pop, full, empty, count, head) SHALL be instantiated twice.

Verification
REQ-034 Write 0x8000_0000_0000_0001 to OUT_BUF, net_polarity=0, net_ro=1 -> net_so=1 next cycle, net_do matches; polarity=1 -> net_so=0.
REQ-035 DEPTH=4, net_ro=0, write 5 words -> OUT_STATUS reads LSB=1, count=4, ovf=1; write OUT_STATUS -> ovf=0.
REQ-036 net_si with 4 words 1..4 -> net_ri=0; 5th net_si ignored; four IN_BUF reads return 1,2,3,4; 5th returns 0.
REQ-037 Input full, IN_BUF read and net_si same cycle -> only read pops (net_ri=0), count 3 afterward; next net_si accepted, count 4.
REQ-038 Output full, net_so=1 and OUT_BUF write same cycle -> count stays 4, ovf stays 0, new word last out.
REQ-039 reset asserted with 3 words in each FIFO -> both counts 0, d_out=0, net_ri=1, net_so=0.

Source files
------------

// File: rtl/nic_pkg.sv
// NIC shared definitions: register map and status word layout.
package nic_pkg;

  typedef enum logic [1:0] {
    ADDR_IN_BUF     = 2'b00,
    ADDR_IN_STATUS  = 2'b01,
    ADDR_OUT_BUF    = 2'b10,
    ADDR_OUT_STATUS = 2'b11
  } nic_addr_e;

  // Status word: flag in LSB, occupancy above it, overflow above that.
  localparam int ST_FLAG_BIT = 0;
  localparam int ST_CNT_LSB  = 1;

  function automatic int st_ovf_bit(input int cnt_w);
    return ST_CNT_LSB + cnt_w;
  endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with occupancy count; pop frees a slot for a same-cycle push.
module nic_sync_fifo
  import nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    if (do_push) wr_d = wr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/nic_fifo.sv
// Network interface: processor-mapped input/output FIFOs to a VC-phased router.
module nic_fifo
  import nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic [DATA_W-1:0] d_out,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam int OVF_BIT = st_ovf_bit(CNT_W);

  logic              in_full, in_empty, out_full, out_empty;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  logic [DATA_W-1:0] in_head, out_head;
  logic [DATA_W-1:0] in_stat, out_stat;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              ovf_q, ovf_d;
  logic              rd_en, wr_en, in_pop, out_push;
  nic_addr_e         sel;

  assign sel      = nic_addr_e'(addr);
  assign rd_en    = nicEn && !nicWrEn;
  assign wr_en    = nicEn && nicWrEn;
  assign in_pop   = rd_en && (sel == ADDR_IN_BUF);
  assign out_push = wr_en && (sel == ADDR_OUT_BUF);

  // The MSB of a network word is its VC; send only in the matching phase.
  assign net_so = !out_empty && net_ro &&
                  (out_head[DATA_W-1] == ~net_polarity);
  assign net_do = out_head;
  assign net_ri = !in_full;
  assign d_out  = d_out_q;

  nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in (
    .clk     (clk),
    .reset   (reset),
    .push_i  (net_si && net_ri),
    .pop_i   (in_pop),
    .din_i   (net_di),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_cnt),
    .head_o  (in_head)
  );

  nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out (
    .clk     (clk),
    .reset   (reset),
    .push_i  (out_push),
    .pop_i   (net_so),
    .din_i   (d_in),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_cnt),
    .head_o  (out_head)
  );

  always_comb begin
    in_stat  = '0;
    out_stat = '0;
    in_stat[ST_FLAG_BIT]          = !in_empty;
    in_stat[ST_CNT_LSB +: CNT_W]  = in_cnt;
    out_stat[ST_FLAG_BIT]         = out_full;
    out_stat[ST_CNT_LSB +: CNT_W] = out_cnt;
    out_stat[OVF_BIT]             = ovf_q;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && (sel == ADDR_OUT_STATUS)) ovf_d = 1'b0;
    if (out_push && out_full && !net_so)   ovf_d = 1'b1;
  end

  always_comb begin
    d_out_d = d_out_q;
    if (!nicEn) begin
      d_out_d = '0;
    end else if (!nicWrEn) begin
      unique case (sel)
        ADDR_IN_BUF:     d_out_d = in_head;
        ADDR_IN_STATUS:  d_out_d = in_stat;
        ADDR_OUT_BUF:    d_out_d = '0;
        ADDR_OUT_STATUS: d_out_d = out_stat;
        default:         d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nic_fifo.sv
// Directed bench for nic_fifo at DATA_W=64, DEPTH=4.
module tb_nic_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic        nicEn, nicWrEn;
  logic [63:0] d_out;
  logic        net_so, net_ro;
  logic [63:0] net_do;
  logic        net_polarity, net_si, net_ri;
  logic [63:0] net_di;

  int errors = 0;
  int checks = 0;
  logic [63:0] rv;

  localparam logic [1:0] IN_BUF = 2'b00, IN_ST = 2'b01;
  localparam logic [1:0] OUT_BUF = 2'b10, OUT_ST = 2'b11;

  nic_fifo dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .d_out(d_out),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
    tick();
    nicEn = 0; nicWrEn = 0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [63:0] d);
    nicEn = 1; nicWrEn = 0; addr = a;
    tick();
    d = d_out;
    nicEn = 0;
  endtask

  task automatic net_push(input logic [63:0] d);
    net_si = 1; net_di = d;
    tick();
    net_si = 0;
  endtask

  initial begin
    reset = 1; addr = 0; d_in = 0; nicEn = 0; nicWrEn = 0;
    net_ro = 0; net_polarity = 0; net_si = 0; net_di = 0;
    tick(); tick();
    reset = 0;
    check("rst_so", {63'd0, net_so}, 64'd0);
    check("rst_ri", {63'd0, net_ri}, 64'd1);
    check("rst_dout", d_out, 64'd0);
    check("rst_do", net_do, 64'd0);
    cpu_rd(IN_ST, rv);  check("rst_in_st", rv, 64'd0);
    cpu_rd(OUT_ST, rv); check("rst_out_st", rv, 64'd0);

    // send on matching polarity
    net_ro = 1; net_polarity = 0;
    cpu_wr(OUT_BUF, 64'h8000_0000_0000_0001);
    check("so_match", {63'd0, net_so}, 64'd1);
    check("do_head", net_do, 64'h8000_0000_0000_0001);
    net_polarity = 1; #1;
    check("so_wrong_pol", {63'd0, net_so}, 64'd0);
    net_polarity = 0;
    tick();
    net_ro = 0;
    check("do_empty", net_do, 64'd0);
    cpu_rd(OUT_ST, rv); check("out_drained", rv, 64'd0);

    // overflow
    for (int i = 0; i < 5; i++) cpu_wr(OUT_BUF, 64'h10 + 64'(i));
    cpu_rd(OUT_ST, rv); check("out_ovf_st", rv, 64'h19);
    check("out_head_first", net_do, 64'h10);
    cpu_wr(OUT_ST, 64'd0);
    cpu_rd(OUT_ST, rv); check("ovf_clear", rv, 64'h09);

    // full: send and write same cycle
    net_ro = 1; net_polarity = 1;
    nicEn = 1; nicWrEn = 1; addr = OUT_BUF; d_in = 64'h55;
    #1;
    check("full_so", {63'd0, net_so}, 64'd1);
    tick();
    nicEn = 0; nicWrEn = 0; net_ro = 0;
    cpu_rd(OUT_ST, rv); check("full_push_pop_st", rv, 64'h09);
    net_ro = 1;
    check("drain0", net_do, 64'h11); tick();
    check("drain1", net_do, 64'h12); tick();
    check("drain2", net_do, 64'h13); tick();
    check("drain3", net_do, 64'h55); tick();
    check("drain_so", {63'd0, net_so}, 64'd0);
    net_ro = 0;

    // input fill and drain
    for (int i = 1; i <= 4; i++) net_push(64'(i));
    check("in_full_ri", {63'd0, net_ri}, 64'd0);
    net_push(64'd5);
    cpu_rd(IN_ST, rv); check("in_full_st", rv, 64'h09);
    for (int i = 1; i <= 4; i++) begin
      cpu_rd(IN_BUF, rv); check("in_rd", rv, 64'(i));
    end
    cpu_rd(IN_BUF, rv); check("in_rd_empty", rv, 64'd0);
    cpu_rd(IN_ST, rv);  check("in_empty_st", rv, 64'd0);

    // full input: read and arrival same cycle
    for (int i = 1; i <= 4; i++) net_push(64'hA0 + 64'(i));
    nicEn = 1; nicWrEn = 0; addr = IN_BUF; net_si = 1; net_di = 64'hEE;
    #1;
    check("rd_si_ri", {63'd0, net_ri}, 64'd0);
    tick();
    net_si = 0; nicEn = 0;
    check("rd_si_dout", d_out, 64'hA1);
    cpu_rd(IN_ST, rv); check("rd_si_st3", rv, 64'h07);
    net_push(64'hA5);
    cpu_rd(IN_ST, rv); check("rd_si_st4", rv, 64'h09);
    for (int i = 2; i <= 5; i++) begin
      cpu_rd(IN_BUF, rv); check("rd_si_order", rv, 64'hA0 + 64'(i));
    end

    // ignored writes, hold during write, OUT_BUF read
    cpu_wr(IN_BUF, 64'h77);
    cpu_wr(IN_ST, 64'h77);
    cpu_rd(IN_ST, rv); check("in_wr_noeffect", rv, 64'd0);
    net_push(64'h33);
    nicEn = 1; nicWrEn = 0; addr = IN_BUF;
    tick();
    check("rd_33", d_out, 64'h33);
    nicWrEn = 1; addr = IN_ST;
    tick();
    check("dout_hold", d_out, 64'h33);
    nicEn = 0; nicWrEn = 0;
    tick();
    check("dout_idle0", d_out, 64'd0);
    cpu_wr(OUT_BUF, 64'h44);
    cpu_rd(OUT_BUF, rv); check("out_buf_rd0", rv, 64'd0);

    // reset with traffic in flight
    cpu_wr(OUT_BUF, 64'h45);
    cpu_wr(OUT_BUF, 64'h46);
    for (int i = 0; i < 3; i++) net_push(64'hC0 + 64'(i));
    nicEn = 1; nicWrEn = 0; addr = IN_ST;
    tick();
    check("pre_rst_st", d_out, 64'h07);
    reset = 1; addr = IN_BUF; net_si = 1; net_di = 64'hDD;
    tick();
    reset = 0; nicEn = 0; net_si = 0; net_ro = 1; net_polarity = 1;
    #1;
    check("rst2_dout", d_out, 64'd0);
    check("rst2_ri", {63'd0, net_ri}, 64'd1);
    check("rst2_so", {63'd0, net_so}, 64'd0);
    net_ro = 0;
    cpu_rd(IN_ST, rv);  check("rst2_in_st", rv, 64'd0);
    cpu_rd(OUT_ST, rv); check("rst2_out_st", rv, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
